// File: rtl/dsc_mul_sched.sv
// dsc_mul_sched: round-robin front end that time-shares one serial multiplier
// among NUM_REQ requesters. One operand set is accepted at a time and latched.
// The multiplier is then cleared for one cycle and run until it reports done
// or the watchdog expires. The tagged result is held on the response channel
// until the consumer takes it.
//
// Handshake: on both channels a transfer happens on a rising clk edge where
// valid and ready are both high. The scheduler keeps rsp_valid, rsp_id,
// rsp_data and rsp_err stable until that transfer. req_ready is a one-hot
// grant that is raised only in IDLE and only for the arbitration winner.
module dsc_mul_sched #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int WXIP1      = 1,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = (1 << (DATA_WIDTH * NUM_INPUTS)) + 4,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int OP_W      = NUM_INPUTS * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [WXIP1-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    mul_rst_n,
  output logic                    mul_en,
  output logic [OP_W-1:0]         mul_operands,
  input  logic [WXIP1-1:0]        mul_result,
  input  logic                    mul_done,
  output logic [1:0]              dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] run_cnt;
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  ptr_next;

  assign dbg_state = state;

  // Round-robin search: first requester at or after ptr (wrapping) with valid set.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      if (!found && req_valid[(int'(ptr) + o) % NUM_REQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(ptr) + o) % NUM_REQ);
      end
    end
  end

  // Pointer moves to the slot just after the winner so it gets lowest priority next.
  always_comb begin
    ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  // One-hot grant, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && rst && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Scheduler FSM. All outputs except req_ready are registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      run_cnt      <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      mul_rst_n    <= 1'b0;
      mul_en       <= 1'b0;
      mul_operands <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            mul_operands <= req_data[int'(winner)*OP_W +: OP_W];
            rsp_id       <= winner;
            ptr          <= ptr_next;
            busy         <= 1'b1;
            state        <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // Multiplier is held in reset for this one cycle; it starts next cycle.
          run_cnt   <= '0;
          mul_rst_n <= 1'b1;
          mul_en    <= 1'b1;
          state     <= S_RUN;
        end
        S_RUN: begin
          run_cnt <= run_cnt + CNT_W'(1);
          // A done that coincides with the last watchdog cycle still counts as success.
          if (mul_done) begin
            rsp_data  <= mul_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            mul_en    <= 1'b0;
            state     <= S_RESP;
          end else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            mul_en    <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          // Multiplier stays out of reset and disabled so its output is held.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            mul_rst_n <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_mul_sched.sv
// Bench for dsc_mul_sched with a behavioural multiplier stub. A timestamp
// model predicts every output each cycle, a queue scoreboard checks each
// delivered response, and directed scenarios pin literal timing and values.
module tb_dsc_mul_sched;

  localparam int DW  = 5;
  localparam int NI  = 2;
  localparam int WX  = 1;
  localparam int NR  = 4;
  localparam int TO  = (1 << (DW * NI)) + 4;
  localparam int IW  = 2;
  localparam int OPW = DW * NI;
  localparam int RDW = NR * OPW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [RDW-1:0]  req_data;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [WX-1:0]   rsp_data;
  logic            rsp_err;
  logic            busy;
  logic            mul_rst_n;
  logic            mul_en;
  logic [OPW-1:0]  mul_operands;
  logic [WX-1:0]   mul_result;
  logic            mul_done;
  logic [1:0]      dbg_state;

  dsc_mul_sched #(
    .DATA_WIDTH(DW), .NUM_INPUTS(NI), .WXIP1(WX), .NUM_REQ(NR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .mul_rst_n(mul_rst_n), .mul_en(mul_en), .mul_operands(mul_operands),
    .mul_result(mul_result), .mul_done(mul_done), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- multiplier stub ----------------
  // done on the Nth enabled cycle after reset release; stub_n == 0 means never.
  int           stub_n;
  logic [WX-1:0] stub_result;
  int           en_run = 0;
  always @(posedge clk) begin
    if (!mul_rst_n) en_run <= 0;
    else if (mul_en) en_run <= en_run + 1;
  end
  assign mul_done   = mul_en && (stub_n != 0) && (en_run + 1 >= stub_n);
  assign mul_result = stub_result;

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic [IW+WX:0] exp_q[$];
  int             grant_log[$];
  int             en_count = 0;

  // Model: an accepted op at cycle T is cleared at T+1, runs from T+2, and
  // responds at T+2+min(N, TO); it stays busy until the response is taken.
  bit             m_active = 1'b0;
  bit             m_fresh  = 1'b1;
  int             m_t      = 0;
  int             m_rsp_at = 0;
  int             m_id     = 0;
  int             m_ptr    = 0;
  logic [OPW-1:0] m_ops    = '0;
  logic [WX-1:0]  m_data   = '0;
  logic           m_err    = 1'b0;
  int             first;
  int             gid;
  logic [NR-1:0]  e_ready;
  bit             e_valid;
  bit             e_en;
  bit             e_rstn;
  logic [IW+WX:0] got;

  always @(negedge clk) begin
    if (cyc > 0) begin
      first = -1;
      for (int o = 0; o < NR; o++)
        if (first < 0 && req_valid[(m_ptr + o) % NR]) first = (m_ptr + o) % NR;
      e_ready = '0;
      if (!m_active && rst && first >= 0) e_ready[first] = 1'b1;
      e_rstn  = m_active && (cyc >= m_t + 2);
      e_en    = e_rstn && (cyc < m_rsp_at);
      e_valid = m_active && (cyc >= m_rsp_at);

      check("req_ready", req_ready, e_ready);
      check("busy", busy, m_active);
      check("mul_rst_n", mul_rst_n, e_rstn);
      check("mul_en", mul_en, e_en);
      check("rsp_valid", rsp_valid, e_valid);
      check("mul_operands", mul_operands, m_ops);
      if (e_valid) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_data", rsp_data, m_data);
        check("rsp_err", rsp_err, m_err);
      end
      if (m_fresh) begin
        check("rsp_id_reset", rsp_id, 0);
        check("rsp_data_reset", rsp_data, 0);
        check("rsp_err_reset", rsp_err, 0);
      end

      if (mul_en) en_count++;
      if (rst && (req_valid & req_ready) != '0) begin
        gid = 0;
        for (int i = 0; i < NR; i++) if (req_ready[i]) gid = i;
        grant_log.push_back(gid);
      end
      if (rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          got = exp_q.pop_front();
          check("rsp_scoreboard", {rsp_id, rsp_data, rsp_err}, got);
        end
      end

      if (!rst) begin
        m_active = 1'b0; m_fresh = 1'b1; m_ptr = 0; m_id = 0;
        m_ops = '0; m_data = '0; m_err = 1'b0;
        exp_q.delete();
      end else if (m_active) begin
        if (e_valid && rsp_ready) m_active = 1'b0;
      end else if (first >= 0) begin
        m_active = 1'b1; m_fresh = 1'b0; m_t = cyc; m_id = first;
        m_ops = req_data[first*OPW +: OPW];
        m_ptr = (first + 1) % NR;
        if (stub_n != 0 && stub_n <= TO) begin
          m_rsp_at = cyc + 2 + stub_n; m_data = stub_result; m_err = 1'b0;
        end else begin
          m_rsp_at = cyc + 2 + TO; m_data = '0; m_err = 1'b1;
        end
        exp_q.push_back({IW'(m_id), m_data, m_err});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      req_valid   = NR'($urandom_range(0, 15));
      req_data    = RDW'({$urandom(), $urandom()});
      rsp_ready   = 1'($urandom_range(0, 1));
      stub_result = WX'($urandom_range(0, 1));
      stub_n      = $urandom_range(0, 5);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    rst       = 1'b1;
  endtask

  task automatic wait_rsp(input int budget, input string name);
    int w = 0;
    while (!rsp_valid && w < budget) begin step(); w++; end
    check(name, rsp_valid, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int w = 0;
    while (busy && w < budget) begin step(); w++; end
    check(name, busy, 0);
  endtask

  int exp_order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int base;
    int w;
    int t0;
    int en_base;
    logic [IW+WX:0] cap;

    rst = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    stub_n = 0; stub_result = '0;

    // Reset with random inputs
    do_reset(3);
    check("reset_busy", busy, 0);
    check("reset_mul_rst_n", mul_rst_n, 0);
    check("reset_mul_en", mul_en, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_mul_operands", mul_operands, 0);
    check("reset_req_ready", req_ready, 0);

    // Fairness: all requesters pending
    stub_n = 3; stub_result = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) req_data[i*OPW +: OPW] = OPW'($urandom_range(0, 1023));
    base = grant_log.size();
    req_valid = 4'hF;
    w = 0;
    while (grant_log.size() < base + 6 && w < 200) begin step(); w++; end
    req_valid = '0;
    check("fair_grant_count", (grant_log.size() - base >= 6), 1);
    for (int i = 0; i < 6; i++)
      if (base + i < grant_log.size()) check("fair_order", grant_log[base+i], exp_order[i]);
    wait_idle(50, "fair_drain");

    // Single request from requester 2, operands {16,8}, N=10
    stub_n = 10; stub_result = 1'b1; rsp_ready = 1'b1;
    req_data = '0;
    req_data[2*OPW +: OPW] = {5'd16, 5'd8};
    en_base = en_count;
    t0 = cyc;
    req_valid = 4'b0100;
    #1;
    check("single_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    check("single_operands", mul_operands, 10'h208);
    check("single_clear_rst_n", mul_rst_n, 0);
    step();
    check("single_first_en", mul_en, 1);
    wait_rsp(40, "single_rsp");
    check("single_latency", cyc - t0, 12);
    check("single_rsp_id", rsp_id, 2);
    check("single_rsp_data", rsp_data, 1);
    check("single_rsp_err", rsp_err, 0);
    check("single_en_cycles", en_count - en_base, 10);
    step();
    check("single_idle_after", busy, 0);

    // Backpressure with requesters 0 and 1 pending (pointer now at 3)
    stub_n = 4; stub_result = 1'b1; rsp_ready = 1'b0;
    req_valid = 4'b0011;
    wait_rsp(40, "bp_rsp");
    check("bp_rsp_id", rsp_id, 0);
    cap = {rsp_id, rsp_data, rsp_err};
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_rsp_hold", {rsp_id, rsp_data, rsp_err}, cap);
      check("bp_valid_hold", rsp_valid, 1);
      check("bp_req_ready", req_ready, 0);
      check("bp_mul_en", mul_en, 0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_idle", busy, 0);
    check("bp_next_grant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    check("bp_next_busy", busy, 1);
    wait_idle(60, "bp_drain");

    // Timeout: stub never finishes
    stub_n = 0; rsp_ready = 1'b1;
    en_base = en_count;
    t0 = cyc;
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    wait_rsp(TO + 50, "to_rsp");
    check("to_latency", cyc - t0, 1030);
    check("to_en_cycles", en_count - en_base, 1028);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_data", rsp_data, 0);
    check("to_rsp_id", rsp_id, 3);
    wait_idle(10, "to_drain");

    // Reset in RUN cycle 5
    stub_n = 20; stub_result = 1'b1; rsp_ready = 1'b1;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    for (int i = 0; i < 5; i++) step();
    check("mr_run5_en", mul_en, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    stub_n = 5;
    check("mr_busy", busy, 0);
    check("mr_mul_en", mul_en, 0);
    check("mr_mul_rst_n", mul_rst_n, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_operands", mul_operands, 0);
    req_valid = 4'b0011;
    #1;
    check("mr_ptr_reset_grant", req_ready, 4'b0001);
    step();
    req_valid = 4'b0010;
    wait_rsp(40, "mr_rsp0");
    check("mr_rsp0_id", rsp_id, 0);
    step();
    step();
    req_valid = '0;
    wait_rsp(40, "mr_rsp1");
    check("mr_rsp1_id", rsp_id, 1);
    check("mr_rsp1_data", rsp_data, 1);
    check("mr_rsp1_err", rsp_err, 0);
    step();
    wait_idle(10, "mr_drain");
    check("final_queue_empty", exp_q.size(), 0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dsc_mul_sched.md
# dsc_mul_sched

Round-robin scheduler that shares one `dsc_serial_mul` instance among `NUM_REQ` requesters. It accepts an operand set from one requester at a time and latches it. It then clears the multiplier, runs it until `done` or a watchdog timeout, and returns the tagged product on a single response channel. It sits between the core-level operand sources and the serial multiplier datapath.

## Interface
Parameters:
- `DATA_WIDTH`, 5: width of each operand.
- `NUM_INPUTS`, 2: operands per multiply.
- `WXIP1`, 1: product width.
- `NUM_REQ`, 4: number of requesters.
- `TIMEOUT`, (1<<(DATA_WIDTH*NUM_INPUTS))+4: maximum RUN cycles before abort.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request.
- `req_data` in NUM_REQ*NUM_INPUTS*DATA_WIDTH: operands. Requester i occupies slice i, and operand j within it occupies sub-slice j.
- `req_ready` out NUM_REQ: one-hot grant. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out clog2(NUM_REQ): index of the requester that owns the result.
- `rsp_data` out WXIP1: product.
- `rsp_err` out 1: 1 = timeout, data invalid.
- `busy` out 1: state is not IDLE.
- `mul_rst_n` out 1: active-low reset to the multiplier.
- `mul_en` out 1: multiplier enable.
- `mul_operands` out NUM_INPUTS*DATA_WIDTH: latched operands driven to the multiplier `bin_data_in`.
- `mul_result` in WXIP1: multiplier `bin_data_out`.
- `mul_done` in 1: multiplier `done`.

## Operation
FSM states: IDLE, CLEAR, RUN, RESP.

- **IDLE**
  - Arbitration is round-robin starting at pointer `ptr`. The winner is the first i in `ptr, ptr+1, …` (mod NUM_REQ) with `req_valid[i]=1`.
  - `req_ready[winner]=1` combinationally in this cycle only; all other bits are 0.
  - On transfer: latch `req_data` slice into `mul_operands`, store winner id, set `ptr <= winner+1` (mod NUM_REQ), go to CLEAR.
  - No valid request: stay in IDLE.
- **CLEAR** (exactly 1 cycle): `mul_rst_n=0`, `mul_en=0`, clear the RUN counter, go to RUN.
- **RUN**
  - `mul_rst_n=1`, `mul_en=1`, counter increments each cycle.
  - If `mul_done=1`: register `rsp_data<=mul_result`, `rsp_err<=0`, go to RESP.
  - Else if counter == TIMEOUT-1: `rsp_data<=0`, `rsp_err<=1`, go to RESP.
  - If `mul_done` and timeout occur in the same cycle, `mul_done` wins.
- **RESP**
  - `rsp_valid=1`, `mul_en=0`, `mul_rst_n=1` so the multiplier holds its output.
  - `rsp_id`, `rsp_data` and `rsp_err` stay stable until `rsp_ready=1`, then go to IDLE.
- `req_ready` is 0 in every state except IDLE.
- `mul_rst_n=0` in IDLE and CLEAR.
- `busy=1` in CLEAR, RUN and RESP.
- `mul_operands` holds its value from acceptance until the next acceptance.
- Counter width is clog2(TIMEOUT+1); the counter never wraps.

## Timing
- Reset (`rst=0` at a clock edge) applies in any state, including mid-RUN or mid-RESP. Next cycle:
  - State is IDLE and `ptr=0`.
  - `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `rsp_err=0`, `busy=0`.
  - `mul_en=0`, `mul_rst_n=0`, `mul_operands=0`.
  - Any in-flight operation is dropped and produces no response.
- Accept at cycle T: CLEAR at T+1, first RUN cycle at T+2.
- If `mul_done` is high in the k-th RUN cycle (k≥1), `rsp_valid` rises at T+2+k.
- Timeout: `rsp_valid` rises at T+2+TIMEOUT.
- Response handshake at cycle R: IDLE at R+1. The earliest next acceptance is R+1, giving one idle cycle between ops.
- `mul_done` is sampled only in RUN and ignored in every other state.
- `rsp_ready` is ignored unless `rsp_valid=1`.

## Test plan
Use defaults with NUM_REQ=4 and a multiplier stub. The stub asserts `mul_done` on its Nth enabled cycle after `mul_rst_n` rises and returns a programmable result.

- **Reset:** hold `rst=0` 3 cycles with random inputs → every output equals its reset value; `busy=0`.
- **Single request:** `req_valid[2]=1`, operands {16,8}, stub N=10, result 1'b1.
  - `req_ready[2]` pulses at T.
  - `mul_operands={16,8}` from T+1.
  - `mul_rst_n` is low at T+1.
  - `mul_en` is high for T+2..T+11.
  - `rsp_valid` at T+12 with `rsp_id=2`, `rsp_data=1`, `rsp_err=0`.
- **Fairness:** all four `req_valid` held high, stub N=3, `rsp_ready=1` → grant order 0,1,2,3,0,1; no requester is granted twice before the others.
- **Backpressure:** hold `rsp_ready=0` for 5 cycles in RESP with other requests pending → `rsp_*` stable, `req_ready=0`, `mul_en=0`. Release → IDLE next cycle, next grant the cycle after the handshake.
- **Timeout:** stub never asserts done, TIMEOUT=1028 → exactly 1028 `mul_en` cycles, then `rsp_valid` with `rsp_err=1` and `rsp_data=0`.
- **Reset mid-RUN:** drive `rst=0` at RUN cycle 5 → next cycle IDLE, `mul_en=0`, `mul_rst_n=0`, `ptr=0`, no `rsp_valid`. A subsequent request from requester 1 is served normally.
